// File: rtl/fxp_cmult_pipe.sv
// Pipelined signed fixed-point multiplier: dual real products or one complex product,
// rounded back to the input Q format with saturate/wrap and an overflow flag.
module fxp_cmult_pipe #(
    parameter int W      = 11,
    parameter int FRAC   = 8,
    parameter int OUT_W  = 11,
    parameter int STAGES = 3,
    parameter int SAT    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             in_valid,
    input  logic             mode,
    input  logic [W-1:0]     a_re,
    input  logic [W-1:0]     a_im,
    input  logic [W-1:0]     b_re,
    input  logic [W-1:0]     b_im,
    output logic             out_valid,
    output logic [OUT_W-1:0] p_re,
    output logic [OUT_W-1:0] p_im,
    output logic             ovf,
    output logic             ovf_sticky
);

    // Two guard bits above the products: one for the complex combine, one for the round add.
    localparam int CW = 2*W + 2;
    localparam logic signed [CW-1:0] MAX_V = $signed({{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
    localparam logic signed [CW-1:0] MIN_V = ~MAX_V;
    localparam logic signed [CW-1:0] HALF  = $signed({{(CW-1){1'b0}}, 1'b1}) <<< (FRAC-1);

    // Returns {out_of_range, value}
    function automatic logic [OUT_W:0] fit(input logic signed [CW-1:0] s);
        logic signed [CW-1:0] r;
        r = (s + HALF) >>> FRAC;
        if (r > MAX_V)
            fit = (SAT != 0) ? {1'b1, MAX_V[OUT_W-1:0]} : {1'b1, r[OUT_W-1:0]};
        else if (r < MIN_V)
            fit = (SAT != 0) ? {1'b1, MIN_V[OUT_W-1:0]} : {1'b1, r[OUT_W-1:0]};
        else
            fit = {1'b0, r[OUT_W-1:0]};
    endfunction

    logic                  v1, m1;
    logic signed [W-1:0]   ar_q, ai_q, br_q, bi_q;
    logic                  v2, m2;
    logic signed [2*W-1:0] rr, ii, ri, ir;
    logic signed [CW-1:0]  e_rr, e_ii, e_ri, e_ir, s_re, s_im;
    logic [OUT_W:0]        f_re, f_im;
    logic                  v3, ovf3, sticky_q;
    logic [OUT_W-1:0]      re3, im3;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else if (ce) begin
            v1   <= in_valid;
            m1   <= mode;
            ar_q <= $signed(a_re);
            ai_q <= $signed(a_im);
            br_q <= $signed(b_re);
            bi_q <= $signed(b_im);
            v2   <= v1;
            m2   <= m1;
            rr   <= ar_q * br_q;
            ii   <= ai_q * bi_q;
            ri   <= ar_q * bi_q;
            ir   <= ai_q * br_q;
        end
    end

    always_comb begin
        e_rr = {{(CW-2*W){rr[2*W-1]}}, rr};
        e_ii = {{(CW-2*W){ii[2*W-1]}}, ii};
        e_ri = {{(CW-2*W){ri[2*W-1]}}, ri};
        e_ir = {{(CW-2*W){ir[2*W-1]}}, ir};
        s_re = m2 ? (e_rr - e_ii) : e_rr;
        s_im = m2 ? (e_ri + e_ir) : e_ii;
        f_re = fit(s_re);
        f_im = fit(s_im);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v3   <= 1'b0;
            re3  <= '0;
            im3  <= '0;
            ovf3 <= 1'b0;
        end else if (ce) begin
            v3   <= v2;
            re3  <= f_re[OUT_W-1:0];
            im3  <= f_im[OUT_W-1:0];
            ovf3 <= f_re[OUT_W] | f_im[OUT_W];
        end
    end

    if (STAGES > 3) begin : g_dly
        localparam int D = STAGES - 3;
        logic             v_d   [D];
        logic [OUT_W-1:0] re_d  [D];
        logic [OUT_W-1:0] im_d  [D];
        logic             ovf_d [D];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < D; i++) begin
                    v_d[i]   <= 1'b0;
                    re_d[i]  <= '0;
                    im_d[i]  <= '0;
                    ovf_d[i] <= 1'b0;
                end
            end else if (ce) begin
                v_d[0]   <= v3;
                re_d[0]  <= re3;
                im_d[0]  <= im3;
                ovf_d[0] <= ovf3;
                for (int i = 1; i < D; i++) begin
                    v_d[i]   <= v_d[i-1];
                    re_d[i]  <= re_d[i-1];
                    im_d[i]  <= im_d[i-1];
                    ovf_d[i] <= ovf_d[i-1];
                end
            end
        end

        assign out_valid = v_d[D-1];
        assign p_re      = re_d[D-1];
        assign p_im      = im_d[D-1];
        assign ovf       = ovf_d[D-1];
    end else begin : g_nodly
        assign out_valid = v3;
        assign p_re      = re3;
        assign p_im      = im3;
        assign ovf       = ovf3;
    end

    // The presented sample's own overflow shows immediately; the register remembers it once consumed.
    always_ff @(posedge clk) begin
        if (rst)
            sticky_q <= 1'b0;
        else if (ce && out_valid && ovf)
            sticky_q <= 1'b1;
    end

    assign ovf_sticky = sticky_q | (out_valid & ovf);

endmodule

// File: tb/tb_fxp_cmult_pipe.sv
// Directed bench for fxp_cmult_pipe: default build, a wrapping build and a 5-stage build
// share one stimulus stream.
module tb_fxp_cmult_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ce, in_valid, mode;
    logic [10:0] a_re, a_im, b_re, b_im;

    logic        v0, v1, v2, o0, o1, o2, s0, s1, s2;
    logic [10:0] re0, im0, re1, im1, re2, im2;

    fxp_cmult_pipe u0 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .mode(mode),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .out_valid(v0), .p_re(re0), .p_im(im0), .ovf(o0), .ovf_sticky(s0));

    fxp_cmult_pipe #(.SAT(0)) u1 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .mode(mode),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .out_valid(v1), .p_re(re1), .p_im(im1), .ovf(o1), .ovf_sticky(s1));

    fxp_cmult_pipe #(.STAGES(5)) u2 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .mode(mode),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .out_valid(v2), .p_re(re2), .p_im(im2), .ovf(o2), .ovf_sticky(s2));

    int n_cmp = 0;
    int n_bad = 0;

    logic        u1_v, u1_ovf;
    logic [10:0] u1_re;

    logic        mon_en = 1'b0;
    logic [21:0] q0[$];
    logic [21:0] q2[$];

    always @(negedge clk) begin
        if (mon_en && ce) begin
            if (v0) q0.push_back({re0, im0});
            if (v2) q2.push_back({re2, im2});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated sample; u0 checked at capture+2 edges, u2 at capture+4.
    task automatic run1(input string tag, input logic m,
                        input logic [10:0] ar, input logic [10:0] ai,
                        input logic [10:0] br, input logic [10:0] bi,
                        input logic [10:0] ere, input logic [10:0] eim, input logic eovf);
        mode = m; a_re = ar; a_im = ai; b_re = br; b_im = bi;
        in_valid = 1'b1; ce = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check({tag, "_early"}, 32'(v0), 32'd0);
        tick();
        check({tag, "_v"},   32'(v0),  32'd1);
        check({tag, "_re"},  32'(re0), 32'(ere));
        check({tag, "_im"},  32'(im0), 32'(eim));
        check({tag, "_ovf"}, 32'(o0),  32'(eovf));
        check({tag, "_s5_early"}, 32'(v2), 32'd0);
        u1_v = v1; u1_re = re1; u1_ovf = o1;
        tick();
        tick();
        check({tag, "_s5_v"},  32'(v2),  32'd1);
        check({tag, "_s5_re"}, 32'(re2), 32'(ere));
    endtask

    initial begin
        int          stale;
        logic [10:0] hold_re;
        logic        hold_v;

        rst = 1'b1; ce = 1'b0; in_valid = 1'b0; mode = 1'b0;
        a_re = '0; a_im = '0; b_re = '0; b_im = '0;
        repeat (3) tick();
        check("rst_v",   32'(v0),  32'd0);
        check("rst_re",  32'(re0), 32'd0);
        check("rst_im",  32'(im0), 32'd0);
        check("rst_ovf", 32'(o0),  32'd0);
        check("rst_stk", 32'(s0),  32'd0);
        check("rst_v5",  32'(v2),  32'd0);
        rst = 1'b0; ce = 1'b1;
        tick();

        run1("real",    1'b0, 11'h280, 11'h000, 11'h780, 11'h000, 11'h6C0, 11'h000, 1'b0);
        check("real_stk", 32'(s0), 32'd0);
        run1("real_im", 1'b0, 11'h100, 11'h200, 11'h100, 11'h780, 11'h100, 11'h700, 1'b0);
        run1("cplx_sq", 1'b1, 11'h100, 11'h100, 11'h100, 11'h100, 11'h000, 11'h200, 1'b0);
        run1("cplx",    1'b1, 11'h180, 11'h080, 11'h100, 11'h200, 11'h080, 11'h380, 1'b0);
        run1("rnd_pos", 1'b0, 11'h001, 11'h000, 11'h080, 11'h000, 11'h001, 11'h000, 1'b0);
        run1("rnd_neg", 1'b0, 11'h7FF, 11'h000, 11'h080, 11'h000, 11'h000, 11'h000, 1'b0);
        check("pre_sat_stk", 32'(s0), 32'd0);

        run1("sat_pos", 1'b0, 11'h300, 11'h000, 11'h300, 11'h000, 11'h3FF, 11'h000, 1'b1);
        check("sat_stk",      32'(s0),     32'd1);
        check("wrap_v",       32'(u1_v),   32'd1);
        check("wrap_re",      32'(u1_re),  32'h100);
        check("wrap_ovf",     32'(u1_ovf), 32'd1);
        run1("sat_neg", 1'b0, 11'h400, 11'h000, 11'h300, 11'h000, 11'h400, 11'h000, 1'b1);
        run1("cplx_fs", 1'b1, 11'h400, 11'h400, 11'h400, 11'h400, 11'h000, 11'h3FF, 1'b1);
        tick();
        check("stk_hold", 32'(s0), 32'd1);

        // Stream of 8 with a 5-cycle stall after the 4th capture
        mon_en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            if (k == 5) begin
                ce = 1'b0; in_valid = 1'b1;
                a_re = 11'h7FF; a_im = 11'h7FF; b_re = 11'h7FF; b_im = 11'h7FF;
                hold_re = re0; hold_v = v0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    check("stall_v",  32'(v0),  32'(hold_v));
                    check("stall_re", 32'(re0), 32'(hold_re));
                end
                ce = 1'b1;
            end
            mode = 1'b0;
            a_re = 11'(k * 64); a_im = 11'(k * 3);
            b_re = 11'h100;     b_im = 11'h100;
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        repeat (8) tick();
        mon_en = 1'b0;
        check("stream_cnt",  32'(q0.size()), 32'd8);
        check("stream5_cnt", 32'(q2.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < q0.size())
                check("stream_val", 32'(q0[i]), 32'({11'((i + 1) * 64), 11'((i + 1) * 3)}));
            if (i < q2.size())
                check("stream5_val", 32'(q2[i]), 32'({11'((i + 1) * 64), 11'((i + 1) * 3)}));
        end

        // Reset with three overflowing samples in flight
        check("pre_rst_stk", 32'(s0), 32'd1);
        mode = 1'b0; a_re = 11'h300; b_re = 11'h300; a_im = '0; b_im = '0;
        in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_v",    32'(v0), 32'd0);
        check("mid_rst_stk",  32'(s0), 32'd0);
        check("mid_rst_v5",   32'(v2), 32'd0);
        check("mid_rst_stk5", 32'(s2), 32'd0);
        stale = 0;
        repeat (6) begin
            tick();
            if (v0 || v2 || s0 || s2) stale++;
        end
        check("no_stale", 32'(stale), 32'd0);
        run1("post_rst", 1'b0, 11'h280, 11'h000, 11'h780, 11'h000, 11'h6C0, 11'h000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
